// File: rtl/div_seq_ctrl_pkg.sv
// Shared types, key codes and BCD helpers for the divider sequencing controller.
package divctrl_pkg;

    typedef enum logic [2:0] {
        S_ENTER_A,
        S_ENTER_B,
        S_START,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [3:0] KEY_DIV       = 4'hA;
    localparam logic [3:0] KEY_EQ        = 4'hB;
    localparam logic [3:0] KEY_CLR       = 4'hC;
    localparam logic [7:0] BLANK_OPERAND = 8'h0F;

    // Operands never exceed 15, so the tens digit is only ever 0 or 1.
    function automatic logic [3:0] bcd_to_bin(input logic [7:0] bcd);
        logic [3:0] units;
        units = (bcd[3:0] == 4'hF) ? 4'h0 : bcd[3:0];
        return (bcd[7:4] != 4'h0) ? 4'(units + 4'd10) : units;
    endfunction

    function automatic logic [7:0] bin_to_bcd(input logic [3:0] bin);
        return (bin >= 4'd10) ? {4'h1, 4'(bin - 4'd10)} : {4'h0, bin};
    endfunction

endpackage

// File: rtl/div_seq_ctrl_operand_entry.sv
// One 2-digit BCD operand register fed by keypad digits; value is limited to 0..15.
module operand_entry
    import divctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       load,
    input  logic       append,
    input  logic [3:0] digit,
    output logic [7:0] value,
    output logic       nonblank,
    output logic       is_zero
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            value <= BLANK_OPERAND;
        end else if (load) begin
            value <= {4'h0, digit};
        end else if (append) begin
            // A second digit is accepted only after a leading 1 and only up to 5.
            if (value[3:0] == 4'hF) begin
                value <= {4'h0, digit};
            end else if (value == 8'h01 && digit <= 4'd5) begin
                value <= {4'h1, digit};
            end
        end
    end

    always_comb begin
        nonblank = (value[3:0] != 4'hF);
        is_zero  = nonblank && (bcd_to_bin(value) == 4'h0);
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// Keypad-to-divider sequencer: operand entry, start pulse, latency wait, result latch.
// Optional DIVCTRL_BCD_OUT_EN: results are latched as 2-digit BCD instead of binary.
module div_seq_ctrl
    import divctrl_pkg::*;
#(
    parameter int DIV_LATENCY = 5,
    parameter int CNT_W       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [7:0] div_a_bcd,
    output logic [7:0] div_b_bcd,
    output logic       div_start,
    input  logic [3:0] div_q,
    input  logic [3:0] div_r,
    output logic [7:0] res_q,
    output logic [7:0] res_r,
    output logic       res_valid,
    output logic       err_div0,
    output logic       busy
);

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic               is_digit, is_clr, key_div, key_eq;
    logic               a_clear, a_load, a_append, b_clear, b_append;
    logic               a_nonblank, b_nonblank, b_zero, unused_a_zero;
    logic               latch;

    operand_entry u_op_a (
        .clk      (clk),
        .rst      (rst),
        .clear    (a_clear),
        .load     (a_load),
        .append   (a_append),
        .digit    (key_code),
        .value    (div_a_bcd),
        .nonblank (a_nonblank),
        .is_zero  (unused_a_zero)
    );

    operand_entry u_op_b (
        .clk      (clk),
        .rst      (rst),
        .clear    (b_clear),
        .load     (1'b0),
        .append   (b_append),
        .digit    (key_code),
        .value    (div_b_bcd),
        .nonblank (b_nonblank),
        .is_zero  (b_zero)
    );

    always_comb begin
        is_digit = key_valid && (key_code <= 4'd9);
        is_clr   = key_valid && (key_code == KEY_CLR);
        key_div  = key_valid && (key_code == KEY_DIV);
        key_eq   = key_valid && (key_code == KEY_EQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_ENTER_A;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        a_clear    = 1'b0;
        a_load     = 1'b0;
        a_append   = 1'b0;
        b_clear    = 1'b0;
        b_append   = 1'b0;
        latch      = 1'b0;
        if (is_clr) begin
            // Clear wins everywhere, including an in-flight division whose result is dropped.
            state_next = S_ENTER_A;
            a_clear    = 1'b1;
            b_clear    = 1'b1;
        end else begin
            unique case (state)
                S_ENTER_A: begin
                    if (is_digit) begin
                        a_append = 1'b1;
                    end else if (key_div && a_nonblank) begin
                        state_next = S_ENTER_B;
                    end
                end
                S_ENTER_B: begin
                    if (is_digit) begin
                        b_append = 1'b1;
                    end else if (key_eq && b_nonblank) begin
                        state_next = b_zero ? S_ERR : S_START;
                    end
                end
                S_START: state_next = S_WAIT;
                S_WAIT: begin
                    if (cnt == '0) begin
                        latch      = 1'b1;
                        state_next = S_DONE;
                    end
                end
                S_DONE: begin
                    if (is_digit) begin
                        a_load     = 1'b1;
                        b_clear    = 1'b1;
                        state_next = S_ENTER_A;
                    end
                end
                S_ERR:   state_next = S_ERR;
                default: state_next = S_ENTER_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == S_START) begin
            cnt <= CNT_W'(DIV_LATENCY - 1);
        end else if (state == S_WAIT && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
            res_r <= '0;
        end else if (latch) begin
`ifdef DIVCTRL_BCD_OUT_EN
            res_q <= bin_to_bcd(div_q);
            res_r <= bin_to_bcd(div_r);
`else
            res_q <= {4'h0, div_q};
            res_r <= {4'h0, div_r};
`endif
        end
    end

    always_comb begin
        div_start = (state == S_START);
        busy      = (state == S_START) || (state == S_WAIT);
        res_valid = (state == S_DONE);
        err_div0  = (state == S_ERR);
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl with a behavioural 5-cycle divider on div_q/div_r.
module tb_div_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_code;
    logic [7:0] div_a_bcd, div_b_bcd;
    logic       div_start;
    logic [3:0] div_q, div_r;
    logic [7:0] res_q, res_r;
    logic       res_valid, err_div0, busy;

    int checks = 0;
    int errors = 0;
    int start_count = 0;

    div_seq_ctrl #(.DIV_LATENCY(5), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .div_a_bcd (div_a_bcd),
        .div_b_bcd (div_b_bcd),
        .div_start (div_start),
        .div_q     (div_q),
        .div_r     (div_r),
        .res_q     (res_q),
        .res_r     (res_r),
        .res_valid (res_valid),
        .err_div0  (err_div0),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic int bcd2int(input logic [7:0] b);
        int u;
        u = (b[3:0] == 4'hF) ? 0 : int'(b[3:0]);
        return int'(b[7:4]) * 10 + u;
    endfunction

    // Divider model: outputs hold 4'hF until four iteration clocks after the start clock.
    int  m_cnt = 0;
    int  m_a = 0, m_b = 1;
    logic m_busy = 1'b0;
    always @(posedge clk) begin
        if (div_start) begin
            start_count <= start_count + 1;
            m_a    <= bcd2int(div_a_bcd);
            m_b    <= bcd2int(div_b_bcd);
            m_cnt  <= 0;
            m_busy <= 1'b1;
            div_q  <= 4'hF;
            div_r  <= 4'hF;
        end else if (m_busy) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 3) begin
                div_q  <= 4'(m_a / m_b);
                div_r  <= 4'(m_a % m_b);
                m_busy <= 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] c);
        key_valid = 1'b1;
        key_code  = c;
        step();
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    // Steps until res_valid; n counts clocks after the '=' key edge.
    task automatic wait_result(output int n, output logic ok);
        n = 0;
        while (!res_valid && n < 30) begin
            step();
            n++;
        end
        ok = res_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        key_valid = 1'b0;
        key_code = 4'h0;
        repeat (2) step();
        checks++;
        if (div_a_bcd !== 8'h0F || div_b_bcd !== 8'h0F || div_start !== 1'b0 ||
            res_q !== 8'h00 || res_r !== 8'h00 || res_valid !== 1'b0 ||
            err_div0 !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: a=%h b=%h st=%b q=%h r=%h v=%b e=%b busy=%b, required a=0f b=0f others 0",
                     div_a_bcd, div_b_bcd, div_start, res_q, res_r, res_valid, err_div0, busy);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic_div();
        int n;
        logic ok;
        logic stable;
        press(4'h1); press(4'h3); press(4'hA); press(4'h4); press(4'hB);
        checks++;
        if (div_start !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_pulse: div_start=%b busy=%b, required 1 1", div_start, busy);
        end
        checks++;
        if (div_a_bcd !== 8'h13 || div_b_bcd !== 8'h04) begin
            errors++;
            $display("FAIL operands_13_4: a=%h b=%h, required 13 04", div_a_bcd, div_b_bcd);
        end
        step();
        checks++;
        if (div_start !== 1'b0) begin
            errors++;
            $display("FAIL start_one_cycle: div_start=%b, required 0", div_start);
        end
        n = 1;
        stable = 1'b1;
        while (!res_valid && n < 30) begin
            if (div_a_bcd !== 8'h13 || div_b_bcd !== 8'h04) stable = 1'b0;
            step();
            n++;
        end
        ok = res_valid;
        checks++;
        if (!ok || n != 6) begin
            errors++;
            $display("FAIL result_latency: valid=%b after %0d clocks, required 6", ok, n);
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL operand_stable: operands changed during wait, required 13/04 held");
        end
        checks++;
        if (res_q !== 8'h03 || res_r !== 8'h01) begin
            errors++;
            $display("FAIL result_13_4: q=%h r=%h, required 03 01", res_q, res_r);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic ok;
        press(4'h7);
        checks++;
        if (res_valid !== 1'b0 || div_a_bcd !== 8'h07 || div_b_bcd !== 8'h0F) begin
            errors++;
            $display("FAIL done_digit_reload: v=%b a=%h b=%h, required 0 07 0f", res_valid, div_a_bcd, div_b_bcd);
        end
        press(4'hA); press(4'h2); press(4'hB);
        wait_result(n, ok);
        checks++;
        if (!ok || res_q !== 8'h03 || res_r !== 8'h01) begin
            errors++;
            $display("FAIL result_7_2: v=%b q=%h r=%h, required 1 03 01", ok, res_q, res_r);
        end
    endtask

    task automatic test_div_zero();
        int s0;
        press(4'hC);
        s0 = start_count;
        press(4'h9); press(4'hA); press(4'h0); press(4'hB);
        repeat (8) step();
        checks++;
        if (err_div0 !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL div0_flag: err=%b busy=%b, required 1 0", err_div0, busy);
        end
        checks++;
        if (start_count != s0) begin
            errors++;
            $display("FAIL div0_no_start: starts=%0d, required %0d", start_count, s0);
        end
        press(4'hC);
        checks++;
        if (err_div0 !== 1'b0 || div_a_bcd !== 8'h0F || div_b_bcd !== 8'h0F) begin
            errors++;
            $display("FAIL div0_clear: err=%b a=%h b=%h, required 0 0f 0f", err_div0, div_a_bcd, div_b_bcd);
        end
        press(4'h5);
        checks++;
        if (div_a_bcd !== 8'h05) begin
            errors++;
            $display("FAIL clear_to_enter_a: a=%h, required 05", div_a_bcd);
        end
    endtask

    task automatic test_entry_limits();
        int n;
        logic ok;
        press(4'hC); press(4'h1); press(4'h7);
        checks++;
        if (div_a_bcd !== 8'h01) begin
            errors++;
            $display("FAIL entry_reject_17: a=%h, required 01", div_a_bcd);
        end
        press(4'hC); press(4'h2); press(4'h5);
        checks++;
        if (div_a_bcd !== 8'h02) begin
            errors++;
            $display("FAIL entry_reject_25: a=%h, required 02", div_a_bcd);
        end
        press(4'hC); press(4'hA);
        checks++;
        if (busy !== 1'b0 || div_a_bcd !== 8'h0F) begin
            errors++;
            $display("FAIL div_on_blank_a: busy=%b a=%h, required 0 0f", busy, div_a_bcd);
        end
        press(4'h1); press(4'h5); press(4'hA); press(4'hB); press(4'h1); press(4'hB);
        wait_result(n, ok);
        checks++;
`ifdef DIVCTRL_BCD_OUT_EN
        if (!ok || res_q !== 8'h15 || res_r !== 8'h00) begin
            errors++;
            $display("FAIL result_15_1: v=%b q=%h r=%h, required 1 15 00", ok, res_q, res_r);
        end
`else
        if (!ok || res_q !== 8'h0F || res_r !== 8'h00) begin
            errors++;
            $display("FAIL result_15_1: v=%b q=%h r=%h, required 1 0f 00", ok, res_q, res_r);
        end
`endif
    endtask

    task automatic test_abort();
        int n;
        logic ok;
        logic seen;
        press(4'hC);
        press(4'h1); press(4'h3); press(4'hA); press(4'h4); press(4'hB);
        step();
        press(4'hC);
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || div_a_bcd !== 8'h0F) begin
            errors++;
            $display("FAIL abort_clear: busy=%b v=%b a=%h, required 0 0 0f", busy, res_valid, div_a_bcd);
        end
        seen = 1'b0;
        repeat (10) begin
            step();
            if (res_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_no_result: res_valid rose after abort, required 0");
        end
        press(4'h8); press(4'hA); press(4'h3); press(4'hB);
        wait_result(n, ok);
        checks++;
        if (!ok || res_q !== 8'h02 || res_r !== 8'h02) begin
            errors++;
            $display("FAIL result_8_3: v=%b q=%h r=%h, required 1 02 02", ok, res_q, res_r);
        end
    endtask

    task automatic test_reset_in_wait();
        logic seen;
        press(4'hC);
        press(4'h6); press(4'hA); press(4'h2); press(4'hB);
        step();
        press(4'h9);
        press(4'hA);
        checks++;
        if (div_a_bcd !== 8'h06 || div_b_bcd !== 8'h02 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wait_keys_dropped: a=%h b=%h busy=%b, required 06 02 1", div_a_bcd, div_b_bcd, busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (div_a_bcd !== 8'h0F || div_b_bcd !== 8'h0F || div_start !== 1'b0 ||
            res_q !== 8'h00 || res_r !== 8'h00 || res_valid !== 1'b0 ||
            err_div0 !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_wait: a=%h b=%h st=%b q=%h r=%h v=%b e=%b busy=%b, required a=0f b=0f others 0",
                     div_a_bcd, div_b_bcd, div_start, res_q, res_r, res_valid, err_div0, busy);
        end
        seen = 1'b0;
        repeat (8) begin
            step();
            if (res_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_no_result: activity after reset, required idle");
        end
    endtask

    task automatic test_bcd_out();
        int n;
        logic ok;
        press(4'hC);
        press(4'h1); press(4'h4); press(4'hA); press(4'h1); press(4'hB);
        wait_result(n, ok);
        checks++;
`ifdef DIVCTRL_BCD_OUT_EN
        if (!ok || res_q !== 8'h14 || res_r !== 8'h00) begin
            errors++;
            $display("FAIL result_14_1: v=%b q=%h r=%h, required 1 14 00", ok, res_q, res_r);
        end
`else
        if (!ok || res_q !== 8'h0E || res_r !== 8'h00) begin
            errors++;
            $display("FAIL result_14_1: v=%b q=%h r=%h, required 1 0e 00", ok, res_q, res_r);
        end
`endif
        press(4'hF);
        checks++;
        if (res_valid !== 1'b1 || div_a_bcd !== 8'h14) begin
            errors++;
            $display("FAIL undefined_key_noop: v=%b a=%h, required 1 14", res_valid, div_a_bcd);
        end
    endtask

    initial begin
        test_reset();
        test_basic_div();
        test_back_to_back();
        test_div_zero();
        test_entry_limits();
        test_abort();
        test_reset_in_wait();
        test_bcd_out();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Sequencing controller for the 4-bit restoring divider (A/B BCD in, Q/R out, 1-cycle start pulse, bit-serial over 4 cycles).
- Assembles dividend and divisor from keypad key events and drives the divider's BCD inputs and start pulse.
- Waits out the divider latency, then latches quotient/remainder for the display path and traps divide-by-zero before the divider is started.
- Sits between the keypad scanner/debouncer and the divider; the divider's own reset is tied to the inverse of rst.

Parameters:
- DIV_LATENCY, 5, clocks from the div_start pulse until the divider's cociente/resto are final (1 load + 4 iterations).
- CNT_W, 3, width of the latency counter; must satisfy 2^CNT_W > DIV_LATENCY.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- key_valid  in  1  one-cycle strobe; key_code is valid this cycle.
- key_code  in  4  0x0–0x9 digit, 0xA divide, 0xB equals, 0xC clear, others ignored.
- div_a_bcd  out  8  to divider dividend, {tens, units}.
- div_b_bcd  out  8  to divider divisor, {tens, units}.
- div_start  out  1  one-cycle start pulse to divider.
- div_q  in  4  divider quotient.
- div_r  in  4  divider remainder.
- res_q  out  8  latched quotient (binary zero-extended, or BCD per optional feature).
- res_r  out  8  latched remainder (same format).
- res_valid  out  1  high while the result is held.
- err_div0  out  1  high while a divide-by-zero error is held.
- busy  out  1  high in S_START and S_WAIT.

Behaviour:
- Reset (rst=1 at a rising edge): state=S_ENTER_A; both operands=8'h0F (tens 0, units blank); div_start=0; res_q=res_r=0; res_valid=0; err_div0=0; busy=0; counter=0.
- Operand entry rules, applied to the current operand:
  - Blank operand + digit d: becomes {0,d}.
  - Operand {0,1} + digit d in 0..5: becomes {1,d}.
  - Any other digit: ignored, so values stay in 0..15.
  - Operand value = tens*10 + units, with blank units = 0.
- States:
  - S_ENTER_A: digits edit A. Key 0xA → S_ENTER_B, only if A is non-blank; otherwise ignored.
  - S_ENTER_B: digits edit B. Key 0xB → S_START if B is non-blank and its value ≠ 0; → S_ERR if its value = 0; ignored if B is blank.
  - S_START: div_start=1 for exactly this cycle; counter loads DIV_LATENCY-1; next state S_WAIT.
  - S_WAIT: counter decrements each cycle. At 0: latch div_q/div_r into res_q/res_r, set res_valid, go to S_DONE. First valid result appears DIV_LATENCY+1 clocks after the 0xB key cycle.
  - S_DONE: holds the result. A digit key clears res_valid, loads A with that digit, blanks B, and goes to S_ENTER_A.
  - S_ERR: err_div0=1; the divider is never started.
- Clear key 0xC, from any state:
  - Blanks both operands, clears res_valid and err_div0, returns to S_ENTER_A.
  - In S_START/S_WAIT it aborts: the result is discarded and the divider's output is never latched.
- All key events in S_START/S_WAIT other than 0xC are dropped. key_valid with an undefined code is a no-op.
- div_a_bcd/div_b_bcd are driven straight from the operand registers and stay stable from S_START through the end of S_WAIT.

Optional Feature:
- DIVCTRL_BCD_OUT_EN defined: res_q/res_r hold 2-digit BCD (e.g. quotient 12 → 8'h12), converted at the latch cycle. Latency is unchanged.
- Not defined: res_q/res_r = {4'h0, binary value}.

Decomposition:
- Package divctrl_pkg:
  - state enum (S_ENTER_A, S_ENTER_B, S_START, S_WAIT, S_DONE, S_ERR).
  - key code constants KEY_DIV=4'hA, KEY_EQ=4'hB, KEY_CLR=4'hC.
  - BLANK_OPERAND=8'h0F.
  - function bcd_to_bin (8 → 4 bits).
- Sub-module operand_entry: one 8-bit BCD operand register with digit-append, blank and load controls, and a nonblank/is_zero status. Instantiated twice.

Test Plan:
- Keys 1,3,/,4,= → div_start exactly 1 cycle after '=' key; div_a_bcd=8'h13, div_b_bcd=8'h04; res_valid rises 6 clocks after '='; res_q=3, res_r=1.
- Keys 9,/,0,= → err_div0=1, div_start never asserted; then 0xC → err_div0=0, state S_ENTER_A.
- Keys 1,7 → operand A stays 8'h01 (7 rejected); keys 2,5 → A=8'h02 (second digit rejected); 1,5,/,1,= → res_q=15, res_r=0.
- 0xC asserted 2 cycles after div_start → res_valid stays 0 permanently; next operation 8/3 gives res_q=2, res_r=2.
- rst asserted during S_WAIT → all outputs at reset values the next cycle; key events during S_WAIT other than 0xC produce no operand change.
- With DIVCTRL_BCD_OUT_EN: 1,4,/,1,= → res_q=8'h14, res_r=8'h00; without it → res_q=8'h0E.
